ffn_layer_sequencer: RTL and testbench
======================================

# ffn_layer_sequencer

Control FSM that runs a multi-layer forward pass on the FFN datapath. Per layer it reads the layer's weight word from `weight_buffer`, loads it into the NEURON_NUM×NEURON_NUM systolic array, and streams skewed activations for 2·NEURON_NUM−1 cycles. It then strobes the bias/activation stage to capture results. It sits between the FFN top-level start/config and the `weight_buffer`, `systolic_array` and `bias_activation` instances, replacing the inline FSM in the top.

## Interface
- DATA_WIDTH, 16, activation/weight element width; passed through for consistency checks only
- NEURON_NUM, 4, array dimension N; sets compute window 2N−1
- ADDR_WIDTH, 4, weight_buffer address width; layer index width
- clk  in  1  clock; all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse; accepted only in IDLE
- abort_i  in  1  synchronous abort; highest priority outside IDLE
- layers_i  in  ADDR_WIDTH  number of layers L; sampled on accepted start
- busy_o  out  1  high from the cycle after accepted start through the DONE cycle
- done_o  out  1  one-cycle pulse; run complete
- wbuf_rd_en_o  out  1  weight_buffer read enable
- wbuf_rd_addr_o  out  ADDR_WIDTH  weight_buffer read address = current layer index
- sa_clr_o  out  1  clear array accumulators
- load_en_o  out  1  latch weight_buffer read data into array PEs
- acc_en_o  out  1  array accumulate enable
- skew_cnt_o  out  $clog2(2N)  feed-cycle index 0..2N−2; datapath uses it to select and skew input elements
- capture_o  out  1  bias_activation output register enable
- activ_type_o  out  2  2'b01 (ReLU) for hidden layers; 2'b00 (identity) for the final layer
- layer_o  out  ADDR_WIDTH  current layer index

## Operation
- States: IDLE, RD_REQ, RD_WAIT, LOAD, COMPUTE, CAPTURE, DONE.
- IDLE: when start_i=1, latch L=layers_i and clear layer_o to 0. If L=0, go to DONE; otherwise go to RD_REQ. start_i in any other state is ignored.
- RD_REQ: wbuf_rd_en_o=1, wbuf_rd_addr_o=layer_o. Next state is RD_WAIT, which covers the buffer's 1-cycle read latency.
- RD_WAIT: read data becomes valid at the end of this cycle. Next state LOAD.
- LOAD: load_en_o=1 and sa_clr_o=1 for exactly one cycle. Next state COMPUTE.
- COMPUTE: acc_en_o=1 for exactly 2N−1 cycles. skew_cnt_o counts 0..2N−2 and resets to 0 on exit. Next state CAPTURE.
- CAPTURE: capture_o=1 for one cycle. If layer_o==L−1, go to DONE; otherwise increment layer_o and go to RD_REQ.
- DONE: done_o=1 for one cycle. Next state IDLE.
- activ_type_o is derived combinationally: (layer_o==L−1) ? 2'b00 : 2'b01.
- Strobe outputs are Moore outputs decoded from the state register; no strobe is asserted outside its named state.
- Abort: abort_i=1 in any non-IDLE state forces IDLE on the next edge. There is no done_o, all strobes drop, layer_o resets to 0, and the array contents are don't-care. abort_i in IDLE has no effect. If abort_i and start_i are both high in IDLE, start wins.
- layers_i changes after start are ignored until the next start.
- L=15 (maximum) uses addresses 0..14; layer_o never wraps.

## Timing
- Reset values: state IDLE; busy_o, done_o, wbuf_rd_en_o, sa_clr_o, load_en_o, acc_en_o, capture_o = 0; skew_cnt_o, layer_o, wbuf_rd_addr_o = 0; activ_type_o = 2'b01.
- Reset asserted mid-run returns to IDLE immediately (asynchronous); no done_o follows.
- Per-layer latency: 1+1+1+(2N−1)+1 = 2N+3 cycles, which is 11 for N=4.
- Run latency: done_o is high exactly L·(2N+3)+1 cycles after the start edge. For L=0 this is 1 cycle.
- Back-to-back runs: a new start_i is accepted in the IDLE cycle immediately after DONE.

## Test plan
- Reset: hold rstn=0 with start_i=1 → all outputs at reset values; no state advance; busy_o=0.
- Single layer, N=4, L=1: start → rd_en at cycle 1 (addr 0), load_en at cycle 3, acc_en high at cycles 4–10 (skew 0..6), capture at cycle 11 with activ_type=00, done_o at cycle 12.
- L=3: three read addresses 0,1,2, each 11 cycles apart; activ_type=01 for layers 0–1 and 00 for layer 2; done_o at cycle 34; exactly 3 capture pulses.
- L=0: start → done_o pulse next cycle; zero rd_en/load_en/acc_en/capture pulses.
- Abort at cycle 6 of an L=2 run → IDLE at cycle 7, acc_en=0, no done_o. A new start at cycle 8 then completes normally with done_o at cycle 8+23.
- start_i held high for the whole run plus a layers_i change mid-run → exactly one run using the originally latched L. A second run begins in the IDLE cycle after DONE.

Source files
------------

// File: rtl/ffn_layer_sequencer.sv
// ============================================================================
//  Module      : ffn_layer_sequencer
//  Description : Per-layer read/load/compute/capture control for the FFN
//                weight_buffer -> systolic_array -> bias_activation datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ffn_layer_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int NEURON_NUM = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic [ADDR_WIDTH-1:0]           layers_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            wbuf_rd_en_o,
    output logic [ADDR_WIDTH-1:0]           wbuf_rd_addr_o,
    output logic                            sa_clr_o,
    output logic                            load_en_o,
    output logic                            acc_en_o,
    output logic [$clog2(2*NEURON_NUM)-1:0] skew_cnt_o,
    output logic                            capture_o,
    output logic [1:0]                      activ_type_o,
    output logic [ADDR_WIDTH-1:0]           layer_o
);

    localparam int SKEW_W = $clog2(2*NEURON_NUM);
    localparam logic [SKEW_W-1:0] SKEW_LAST = SKEW_W'(2*NEURON_NUM - 2);

    generate
        if (DATA_WIDTH < 1 || NEURON_NUM < 1 || ADDR_WIDTH < 1) begin : g_param_check
            $error("ffn_layer_sequencer: DATA_WIDTH, NEURON_NUM and ADDR_WIDTH must be positive");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_LOAD    = 3'd3,
        S_COMPUTE = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   layers_q, layers_d;
    logic [ADDR_WIDTH-1:0]   layer_q, layer_d;
    logic [SKEW_W-1:0]       skew_q, skew_d;
    logic [ADDR_WIDTH-1:0]   layer_last;

    // Unsigned wrap for L=0 gives all-ones, which no layer index ever reaches.
    assign layer_last = layers_q - 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            layers_q <= '0;
            layer_q  <= '0;
            skew_q   <= '0;
        end else begin
            state_q  <= state_d;
            layers_q <= layers_d;
            layer_q  <= layer_d;
            skew_q   <= skew_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        layers_d = layers_q;
        layer_d  = layer_q;
        skew_d   = skew_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    layers_d = layers_i;
                    layer_d  = '0;
                    state_d  = (layers_i == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_LOAD;
            S_LOAD: begin
                skew_d  = '0;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (skew_q == SKEW_LAST) begin
                    skew_d  = '0;
                    state_d = S_CAPTURE;
                end else begin
                    skew_d = skew_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (layer_q == layer_last) begin
                    state_d = S_DONE;
                end else begin
                    layer_d = layer_q + 1'b1;
                    state_d = S_RD_REQ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition above except an IDLE start.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            layer_d = '0;
            skew_d  = '0;
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign wbuf_rd_en_o   = (state_q == S_RD_REQ);
    assign wbuf_rd_addr_o = layer_q;
    assign sa_clr_o       = (state_q == S_LOAD);
    assign load_en_o      = (state_q == S_LOAD);
    assign acc_en_o       = (state_q == S_COMPUTE);
    assign skew_cnt_o     = skew_q;
    assign capture_o      = (state_q == S_CAPTURE);
    assign activ_type_o   = (layer_q == layer_last) ? 2'b00 : 2'b01;
    assign layer_o        = layer_q;

endmodule

`default_nettype wire

// File: tb/tb_ffn_layer_sequencer.sv
// ============================================================================
//  Module      : tb_ffn_layer_sequencer
//  Description : Scoreboard bench for ffn_layer_sequencer strobe timing.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ffn_layer_sequencer;

    localparam int N   = 4;
    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int SW  = $clog2(2*N);
    localparam int LAT = 2*N + 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_i;
    logic          abort_i;
    logic [AW-1:0] layers_i;
    logic          busy_o, done_o, wbuf_rd_en_o, sa_clr_o, load_en_o, acc_en_o, capture_o;
    logic [AW-1:0] wbuf_rd_addr_o, layer_o;
    logic [SW-1:0] skew_cnt_o;
    logic [1:0]    activ_type_o;

    ffn_layer_sequencer #(
        .DATA_WIDTH (DW),
        .NEURON_NUM (N),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .layers_i       (layers_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .wbuf_rd_en_o   (wbuf_rd_en_o),
        .wbuf_rd_addr_o (wbuf_rd_addr_o),
        .sa_clr_o       (sa_clr_o),
        .load_en_o      (load_en_o),
        .acc_en_o       (acc_en_o),
        .skew_cnt_o     (skew_cnt_o),
        .capture_o      (capture_o),
        .activ_type_o   (activ_type_o),
        .layer_o        (layer_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
        int aux;
    } ev_t;

    ev_t rd_q[$], ld_q[$], acc_q[$], cap_q[$], done_q[$];
    ev_t me;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  busy_lo = 1;
    int  busy_hi = 0;
    int  rd_cnt = 0, ld_cnt = 0, acc_cnt = 0, cap_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int c, input int v, input int a);
        ev_t e;
        e.cyc = c;
        e.val = v;
        e.aux = a;
        return e;
    endfunction

    // Expected strobe schedule for a run whose start is sampled at the edge ending cycle s.
    task automatic push_run(input int s, input int L);
        for (int k = 0; k < L; k++) begin
            int b;
            b = s + k*LAT;
            rd_q.push_back(mk(b + 1, k, 0));
            ld_q.push_back(mk(b + 3, k, 0));
            for (int j = 0; j < 2*N - 1; j++) acc_q.push_back(mk(b + 4 + j, j, 0));
            cap_q.push_back(mk(b + LAT, k, (k == L - 1) ? 0 : 1));
        end
        done_q.push_back(mk(s + L*LAT + 1, 0, 0));
        busy_lo = s + 1;
        busy_hi = s + L*LAT + 1;
    endtask

    task automatic purge(input int lim);
        while (rd_q.size()   > 0 && rd_q[$].cyc   > lim) void'(rd_q.pop_back());
        while (ld_q.size()   > 0 && ld_q[$].cyc   > lim) void'(ld_q.pop_back());
        while (acc_q.size()  > 0 && acc_q[$].cyc  > lim) void'(acc_q.pop_back());
        while (cap_q.size()  > 0 && cap_q[$].cyc  > lim) void'(cap_q.pop_back());
        while (done_q.size() > 0 && done_q[$].cyc > lim) void'(done_q.pop_back());
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input int L, output int s);
        s        = cyc;
        layers_i = AW'(L);
        start_i  = 1'b1;
        push_run(s, L);
        tick();
        start_i  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq("done_timeout", done_q.size(), 0);
        tick();
    endtask

    // Monitor: pop expectations as strobes appear, flag strobes that never came.
    always @(negedge clk) begin
        if (rstn) begin
            if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                check_eq("rd_missed", cyc, rd_q[0].cyc);
                void'(rd_q.pop_front());
            end
            if (ld_q.size() > 0 && ld_q[0].cyc < cyc) begin
                check_eq("load_missed", cyc, ld_q[0].cyc);
                void'(ld_q.pop_front());
            end
            if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
                check_eq("acc_missed", cyc, acc_q[0].cyc);
                void'(acc_q.pop_front());
            end
            if (cap_q.size() > 0 && cap_q[0].cyc < cyc) begin
                check_eq("capture_missed", cyc, cap_q[0].cyc);
                void'(cap_q.pop_front());
            end
            if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
                check_eq("done_missed", cyc, done_q[0].cyc);
                void'(done_q.pop_front());
            end

            if (wbuf_rd_en_o) begin
                rd_cnt++;
                if (rd_q.size() == 0) check_eq("rd_unexpected", rd_q.size(), 1);
                else begin
                    me = rd_q.pop_front();
                    check_eq("rd_cycle", cyc, me.cyc);
                    check_eq("rd_addr", int'(wbuf_rd_addr_o), me.val);
                    check_eq("rd_layer", int'(layer_o), me.val);
                end
            end
            if (load_en_o) begin
                ld_cnt++;
                if (ld_q.size() == 0) check_eq("load_unexpected", ld_q.size(), 1);
                else begin
                    me = ld_q.pop_front();
                    check_eq("load_cycle", cyc, me.cyc);
                    check_eq("load_sa_clr", int'(sa_clr_o), 1);
                end
            end
            if (acc_en_o) begin
                acc_cnt++;
                if (acc_q.size() == 0) check_eq("acc_unexpected", acc_q.size(), 1);
                else begin
                    me = acc_q.pop_front();
                    check_eq("acc_cycle", cyc, me.cyc);
                    check_eq("acc_skew", int'(skew_cnt_o), me.val);
                end
            end
            if (capture_o) begin
                cap_cnt++;
                if (cap_q.size() == 0) check_eq("capture_unexpected", cap_q.size(), 1);
                else begin
                    me = cap_q.pop_front();
                    check_eq("capture_cycle", cyc, me.cyc);
                    check_eq("capture_layer", int'(layer_o), me.val);
                    check_eq("capture_activ", int'(activ_type_o), me.aux);
                end
            end
            if (done_o) begin
                if (done_q.size() == 0) check_eq("done_unexpected", done_q.size(), 1);
                else begin
                    me = done_q.pop_front();
                    check_eq("done_cycle", cyc, me.cyc);
                end
            end

            check_eq("busy", int'(busy_o), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (!acc_en_o) check_eq("skew_idle", int'(skew_cnt_o), 0);
            if (sa_clr_o != load_en_o) check_eq("sa_clr_vs_load", int'(sa_clr_o), int'(load_en_o));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, d, c0, r0, l0, a0;

        rstn     = 1'b0;
        start_i  = 1'b1;
        abort_i  = 1'b0;
        layers_i = 4'd3;
        repeat (3) tick();

        check_eq("rst_busy",     int'(busy_o), 0);
        check_eq("rst_done",     int'(done_o), 0);
        check_eq("rst_rd_en",    int'(wbuf_rd_en_o), 0);
        check_eq("rst_rd_addr",  int'(wbuf_rd_addr_o), 0);
        check_eq("rst_sa_clr",   int'(sa_clr_o), 0);
        check_eq("rst_load",     int'(load_en_o), 0);
        check_eq("rst_acc",      int'(acc_en_o), 0);
        check_eq("rst_skew",     int'(skew_cnt_o), 0);
        check_eq("rst_capture",  int'(capture_o), 0);
        check_eq("rst_activ",    int'(activ_type_o), 1);
        check_eq("rst_layer",    int'(layer_o), 0);

        rstn    = 1'b1;
        start_i = 1'b0;
        repeat (2) tick();

        // Single layer
        start_run(1, s);
        wait_done(100);

        // Three layers: three captures, final one identity
        c0 = cap_cnt;
        start_run(3, s);
        wait_done(200);
        check_eq("l3_capture_count", cap_cnt - c0, 3);

        // Zero layers: done only
        r0 = rd_cnt; l0 = ld_cnt; a0 = acc_cnt; c0 = cap_cnt;
        start_run(0, s);
        wait_done(20);
        check_eq("l0_rd_count",      rd_cnt - r0, 0);
        check_eq("l0_load_count",    ld_cnt - l0, 0);
        check_eq("l0_acc_count",     acc_cnt - a0, 0);
        check_eq("l0_capture_count", cap_cnt - c0, 0);

        // Abort in cycle 6 of a two-layer run, then a clean restart
        start_run(2, s);
        while (cyc < s + 6) tick();
        abort_i = 1'b1;
        purge(cyc);
        busy_hi = cyc;
        tick();
        abort_i = 1'b0;
        check_eq("abort_busy",  int'(busy_o), 0);
        check_eq("abort_acc",   int'(acc_en_o), 0);
        check_eq("abort_layer", int'(layer_o), 0);
        tick();
        start_run(2, s);
        wait_done(100);

        // start held high; mid-run layers change only affects the follow-on run
        c0       = cap_cnt;
        s        = cyc;
        layers_i = 4'd2;
        start_i  = 1'b1;
        push_run(s, 2);
        d  = s + 2*LAT + 1;
        s2 = d + 1;
        repeat (5) tick();
        layers_i = 4'd7;
        while (cyc < s2) tick();
        check_eq("held_first_captures", cap_cnt - c0, 2);
        push_run(s2, 7);
        tick();
        start_i = 1'b0;
        wait_done(200);
        check_eq("held_total_captures", cap_cnt - c0, 9);

        // Maximum layer count: addresses 0..14
        r0 = rd_cnt;
        start_run(15, s);
        wait_done(400);
        check_eq("l15_rd_count", rd_cnt - r0, 15);

        // Asynchronous reset in the middle of compute
        start_run(3, s);
        while (cyc < s + 5) tick();
        rstn = 1'b0;
        #1;
        check_eq("arst_busy",  int'(busy_o), 0);
        check_eq("arst_acc",   int'(acc_en_o), 0);
        check_eq("arst_layer", int'(layer_o), 0);
        purge(cyc);
        busy_hi = cyc;
        tick();
        rstn = 1'b1;
        repeat (2) tick();
        start_run(1, s);
        wait_done(100);

        repeat (3) tick();
        check_eq("left_rd",      rd_q.size(), 0);
        check_eq("left_load",    ld_q.size(), 0);
        check_eq("left_acc",     acc_q.size(), 0);
        check_eq("left_capture", cap_q.size(), 0);
        check_eq("left_done",    done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
